dual_issue_decode_sb: RTL and testbench



---
 rtl/dual_issue_decode_sb_if.sv | 38 +++
 rtl/dual_issue_decode_sb.sv | 142 ++++++++++++++
 tb/tb_dual_issue_decode_sb.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_issue_decode_sb_if.sv
// rtl/dual_issue_decode_sb_if.sv - fetch/issue/writeback bundle for the dual-issue decode scoreboard
interface dual_issue_decode_sb_if #(
    parameter int NREG = 32,
    parameter int NWB  = 2
);
    localparam int AW = $clog2(NREG);

    // fetch side
    logic              in_valid;
    logic              in_slot1_valid;
    logic [31:0]       in_instr0;
    logic [31:0]       in_instr1;
    logic              in_ready;
    logic              flush;
    // issue side
    logic [1:0]        iss_valid;
    logic              iss_ready;
    logic [2*AW-1:0]   iss_rs1;
    logic [2*AW-1:0]   iss_rs2;
    logic [2*AW-1:0]   iss_rd;
    logic [1:0]        iss_illegal;
    // writeback side
    logic [NWB-1:0]    wb_valid;
    logic [NWB*AW-1:0] wb_rd;
    logic [NREG-1:0]   sb_busy;

    modport master (
        output in_valid, in_slot1_valid, in_instr0, in_instr1, flush,
               iss_ready, wb_valid, wb_rd,
        input  in_ready, iss_valid, iss_rs1, iss_rs2, iss_rd, iss_illegal, sb_busy
    );

    modport slave (
        input  in_valid, in_slot1_valid, in_instr0, in_instr1, flush,
               iss_ready, wb_valid, wb_rd,
        output in_ready, iss_valid, iss_rs1, iss_rs2, iss_rd, iss_illegal, sb_busy
    );
endinterface

// File: rtl/dual_issue_decode_sb.sv
// rtl/dual_issue_decode_sb.sv - dual-slot register decoder with in-order scoreboard issue (option: WB_BYPASS_EN)
module dual_issue_decode_sb #(
    parameter int NREG = 32,
    parameter int NWB  = 2
) (
    input logic                  clk,
    input logic                  rst,
    dual_issue_decode_sb_if.slave bus
);
    localparam int AW = $clog2(NREG);

    // returns {illegal, use_rd, use_rs2, use_rs1} for a 7-bit opcode
    function automatic logic [3:0] dec_use(input logic [6:0] op);
        case (op)
            7'b0110111, 7'b0010111, 7'b1101111: dec_use = 4'b0100;
            7'b1100111, 7'b0000011, 7'b0010011: dec_use = 4'b0101;
            7'b1100011, 7'b0100011:             dec_use = 4'b0011;
            7'b0110011:                         dec_use = 4'b0111;
            default:                            dec_use = 4'b1000;
        endcase
    endfunction

    logic [1:0]         hv_q, hv_d;
    logic [1:0][AW-1:0] rs1_q, rs1_d;
    logic [1:0][AW-1:0] rs2_q, rs2_d;
    logic [1:0][AW-1:0] rd_q, rd_d;
    logic [1:0]         ill_q, ill_d;
    logic [NREG-1:0]    busy_q, busy_d;

    logic [1:0][AW-1:0] n_rs1, n_rs2, n_rd;
    logic [1:0]         n_ill;
    logic [NREG-1:0]    wb_mask, set_mask, busy_eff;
    logic [1:0]         haz, iss_v, fire;
    logic               intra, in_rdy, acc;

    // opcode-independent fields that decode never looks at
    logic unused_instr_bits;
    assign unused_instr_bits = ^{bus.in_instr0[31:25], bus.in_instr0[14:12],
                                 bus.in_instr1[31:25], bus.in_instr1[14:12]};

    // decode the incoming pair; a missing slot 1 decodes to all-zero, legal
    always_comb begin
        logic [31:0] ins;
        logic [3:0]  u;
        logic        present;
        n_rs1 = '0;
        n_rs2 = '0;
        n_rd  = '0;
        n_ill = '0;
        for (int s = 0; s < 2; s++) begin
            ins     = (s == 0) ? bus.in_instr0 : bus.in_instr1;
            present = (s == 0) ? 1'b1 : bus.in_slot1_valid;
            u       = dec_use(ins[6:0]);
            if (present) begin
                n_rs1[s] = u[0] ? ins[19:15] : '0;
                n_rs2[s] = u[1] ? ins[24:20] : '0;
                n_rd[s]  = u[2] ? ins[11:7]  : '0;
                n_ill[s] = u[3];
            end
        end
    end

    // hazard detection, issue, and handshake generation
    always_comb begin
        wb_mask = '0;
        for (int k = 0; k < NWB; k++) begin
            if (bus.wb_valid[k] && (bus.wb_rd[k*AW +: AW] != '0))
                wb_mask[bus.wb_rd[k*AW +: AW]] = 1'b1;
        end
`ifdef WB_BYPASS_EN
        // a writeback landing this cycle already satisfies its consumers
        busy_eff = busy_q & ~wb_mask;
`else
        busy_eff = busy_q;
`endif
        for (int s = 0; s < 2; s++) begin
            haz[s] = ((rs1_q[s] != '0) && busy_eff[rs1_q[s]]) ||
                     ((rs2_q[s] != '0) && busy_eff[rs2_q[s]]) ||
                     ((rd_q[s]  != '0) && busy_eff[rd_q[s]]);
        end
        intra = hv_q[0] && (rd_q[0] != '0) &&
                ((rs1_q[1] == rd_q[0]) || (rs2_q[1] == rd_q[0]) || (rd_q[1] == rd_q[0]));
        iss_v[0] = hv_q[0] & ~haz[0] & ~bus.flush;
        iss_v[1] = hv_q[1] & ~haz[1] & ~bus.flush & (~hv_q[0] | (iss_v[0] & ~intra));
        fire     = iss_v & {2{bus.iss_ready}};
        in_rdy   = ~bus.flush & ((hv_q & ~fire) == 2'b00);
        acc      = bus.in_valid & in_rdy;
    end

    // next hold-register and scoreboard state
    always_comb begin
        hv_d  = hv_q & ~fire;
        rs1_d = rs1_q;
        rs2_d = rs2_q;
        rd_d  = rd_q;
        ill_d = ill_q;
        if (bus.flush) begin
            hv_d = 2'b00;
        end else if (acc) begin
            hv_d  = {bus.in_slot1_valid, 1'b1};
            rs1_d = n_rs1;
            rs2_d = n_rs2;
            rd_d  = n_rd;
            ill_d = n_ill;
        end
        set_mask = '0;
        for (int s = 0; s < 2; s++) begin
            if (fire[s] && (rd_q[s] != '0))
                set_mask[rd_q[s]] = 1'b1;
        end
        // set is applied after clear so a same-cycle set wins
        busy_d    = (busy_q & ~wb_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hv_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            rd_q   <= '0;
            ill_q  <= '0;
            busy_q <= '0;
        end else begin
            hv_q   <= hv_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
            rd_q   <= rd_d;
            ill_q  <= ill_d;
            busy_q <= busy_d;
        end
    end

    assign bus.in_ready    = in_rdy;
    assign bus.iss_valid   = iss_v;
    assign bus.iss_rs1     = rs1_q;
    assign bus.iss_rs2     = rs2_q;
    assign bus.iss_rd      = rd_q;
    assign bus.iss_illegal = ill_q;
    assign bus.sb_busy     = busy_q;
endmodule

// File: tb/tb_dual_issue_decode_sb.sv
// tb/tb_dual_issue_decode_sb.sv - directed self-checking bench for dual_issue_decode_sb
module tb_dual_issue_decode_sb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    dual_issue_decode_sb_if #(.NREG(32), .NWB(2)) bus ();

    dual_issue_decode_sb #(.NREG(32), .NWB(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        tick;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_slot1_valid = 1'b0;
        bus.in_instr0 = '0; bus.in_instr1 = '0;
        bus.flush = 1'b0; bus.iss_ready = 1'b0;
        bus.wb_valid = '0; bus.wb_rd = '0;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        #4;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.iss_valid !== 2'b00) begin n_bad++; $display("FAIL reset_iss_valid: got %b want 00", bus.iss_valid); end
        n_cmp++; if (bus.sb_busy !== 32'h0) begin n_bad++; $display("FAIL reset_sb_busy: got %h want 0", bus.sb_busy); end
        n_cmp++; if (bus.iss_illegal !== 2'b00) begin n_bad++; $display("FAIL reset_illegal: got %b want 00", bus.iss_illegal); end
        n_cmp++; if (bus.iss_rd !== 10'd0) begin n_bad++; $display("FAIL reset_iss_rd: got %h want 0", bus.iss_rd); end
    endtask

    task automatic test_independent;
        do_reset;
        tick;
        bus.in_valid = 1'b1; bus.in_slot1_valid = 1'b1;
        bus.in_instr0 = 32'h00500093; bus.in_instr1 = 32'h00700113; bus.iss_ready = 1'b1;
        #4;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL indep_in_ready: got %b want 1", bus.in_ready); end
        tick;
        bus.in_valid = 1'b0;
        #4;
        n_cmp++; if (bus.iss_valid !== 2'b11) begin n_bad++; $display("FAIL indep_iss_valid: got %b want 11", bus.iss_valid); end
        n_cmp++; if (bus.iss_rd !== {5'd2, 5'd1}) begin n_bad++; $display("FAIL indep_iss_rd: got %h want %h", bus.iss_rd, {5'd2, 5'd1}); end
        tick;
        #4;
        n_cmp++; if (bus.sb_busy !== 32'h6) begin n_bad++; $display("FAIL indep_sb_busy: got %h want 6", bus.sb_busy); end
        n_cmp++; if (bus.iss_valid !== 2'b00) begin n_bad++; $display("FAIL indep_drained: got %b want 00", bus.iss_valid); end
        tick;
        bus.wb_valid = 2'b11; bus.wb_rd = {5'd2, 5'd1};
        tick;
        bus.wb_valid = 2'b00;
        #4;
        n_cmp++; if (bus.sb_busy !== 32'h0) begin n_bad++; $display("FAIL indep_wb_clear: got %h want 0", bus.sb_busy); end
    endtask

    task automatic test_intra_raw;
        do_reset;
        tick;
        bus.in_valid = 1'b1; bus.in_slot1_valid = 1'b1; bus.iss_ready = 1'b1;
        bus.in_instr0 = 32'h00500093; bus.in_instr1 = 32'h001081b3;
        tick;
        bus.in_valid = 1'b0;
        #4;
        n_cmp++; if (bus.iss_valid !== 2'b01) begin n_bad++; $display("FAIL raw_intra_valid: got %b want 01", bus.iss_valid); end
        n_cmp++; if (bus.iss_rs1 !== {5'd1, 5'd0}) begin n_bad++; $display("FAIL raw_rs1: got %h want %h", bus.iss_rs1, {5'd1, 5'd0}); end
        tick;
        #4;
        n_cmp++; if (bus.iss_valid !== 2'b00) begin n_bad++; $display("FAIL raw_stall_valid: got %b want 00", bus.iss_valid); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL raw_stall_ready: got %b want 0", bus.in_ready); end
        n_cmp++; if (bus.sb_busy !== 32'h2) begin n_bad++; $display("FAIL raw_busy_x1: got %h want 2", bus.sb_busy); end
        tick;
        bus.wb_valid = 2'b01; bus.wb_rd = {5'd0, 5'd1};
        #4;
`ifdef WB_BYPASS_EN
        n_cmp++; if (bus.iss_valid !== 2'b10) begin n_bad++; $display("FAIL raw_wb_cycle: got %b want 10", bus.iss_valid); end
        tick;
        bus.wb_valid = 2'b00;
        #4;
        n_cmp++; if (bus.sb_busy !== 32'h8) begin n_bad++; $display("FAIL raw_busy_x3: got %h want 8", bus.sb_busy); end
`else
        n_cmp++; if (bus.iss_valid !== 2'b00) begin n_bad++; $display("FAIL raw_wb_cycle: got %b want 00", bus.iss_valid); end
        tick;
        bus.wb_valid = 2'b00;
        #4;
        n_cmp++; if (bus.iss_valid !== 2'b10) begin n_bad++; $display("FAIL raw_after_wb: got %b want 10", bus.iss_valid); end
        tick;
        #4;
        n_cmp++; if (bus.sb_busy !== 32'h8) begin n_bad++; $display("FAIL raw_busy_x3: got %h want 8", bus.sb_busy); end
`endif
    endtask

    task automatic test_backpressure;
        do_reset;
        tick;
        bus.in_valid = 1'b1; bus.in_slot1_valid = 1'b1; bus.iss_ready = 1'b0;
        bus.in_instr0 = 32'h00500213; bus.in_instr1 = 32'h00700293;
        tick;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #4;
            n_cmp++; if (bus.iss_valid !== 2'b11) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b want 11", i, bus.iss_valid); end
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready[%0d]: got %b want 0", i, bus.in_ready); end
            n_cmp++; if (bus.sb_busy !== 32'h0) begin n_bad++; $display("FAIL bp_busy[%0d]: got %h want 0", i, bus.sb_busy); end
            tick;
        end
        bus.iss_ready = 1'b1;
        #4;
        n_cmp++; if (bus.iss_valid !== 2'b11) begin n_bad++; $display("FAIL bp_release_valid: got %b want 11", bus.iss_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
        tick;
        #4;
        n_cmp++; if (bus.sb_busy !== 32'h30) begin n_bad++; $display("FAIL bp_busy_set: got %h want 30", bus.sb_busy); end
    endtask

    task automatic test_back_to_back;
        do_reset;
        tick;
        bus.in_valid = 1'b1; bus.in_slot1_valid = 1'b1; bus.iss_ready = 1'b1;
        bus.in_instr0 = 32'h00500313; bus.in_instr1 = 32'h00700393;
        tick;
        bus.in_instr0 = 32'h00500413; bus.in_instr1 = 32'h00700493;
        #4;
        n_cmp++; if (bus.iss_valid !== 2'b11) begin n_bad++; $display("FAIL b2b_first_valid: got %b want 11", bus.iss_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b want 1", bus.in_ready); end
        tick;
        bus.in_valid = 1'b0;
        #4;
        n_cmp++; if (bus.iss_valid !== 2'b11) begin n_bad++; $display("FAIL b2b_second_valid: got %b want 11", bus.iss_valid); end
        n_cmp++; if (bus.iss_rd !== {5'd9, 5'd8}) begin n_bad++; $display("FAIL b2b_rd: got %h want %h", bus.iss_rd, {5'd9, 5'd8}); end
        n_cmp++; if (bus.sb_busy !== 32'hC0) begin n_bad++; $display("FAIL b2b_busy_a: got %h want c0", bus.sb_busy); end
        tick;
        #4;
        n_cmp++; if (bus.sb_busy !== 32'h3C0) begin n_bad++; $display("FAIL b2b_busy_b: got %h want 3c0", bus.sb_busy); end
    endtask

    task automatic test_flush;
        do_reset;
        tick;
        bus.in_valid = 1'b1; bus.in_slot1_valid = 1'b0; bus.iss_ready = 1'b1;
        bus.in_instr0 = 32'h00500093;
        tick;
        bus.in_valid = 1'b0;
        tick;
        bus.in_valid = 1'b1; bus.in_instr0 = 32'h001081b3;
        tick;
        bus.in_valid = 1'b0;
        #4;
        n_cmp++; if (bus.iss_valid !== 2'b00) begin n_bad++; $display("FAIL flush_blocked_valid: got %b want 00", bus.iss_valid); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_blocked_ready: got %b want 0", bus.in_ready); end
        tick;
        bus.flush = 1'b1;
        #4;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_cycle_ready: got %b want 0", bus.in_ready); end
        tick;
        bus.flush = 1'b0;
        #4;
        n_cmp++; if (bus.iss_valid !== 2'b00) begin n_bad++; $display("FAIL flush_after_valid: got %b want 00", bus.iss_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_after_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.sb_busy !== 32'h2) begin n_bad++; $display("FAIL flush_busy_kept: got %h want 2", bus.sb_busy); end
        tick;
        bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0; bus.flush = 1'b1;
        bus.wb_valid = 2'b01; bus.wb_rd = {5'd0, 5'd1};
        #4;
        n_cmp++; if (bus.iss_valid !== 2'b00) begin n_bad++; $display("FAIL flush_wb_valid: got %b want 00", bus.iss_valid); end
        tick;
        bus.flush = 1'b0; bus.wb_valid = 2'b00;
        #4;
        n_cmp++; if (bus.sb_busy !== 32'h0) begin n_bad++; $display("FAIL flush_wb_clear: got %h want 0", bus.sb_busy); end
        n_cmp++; if (bus.iss_valid !== 2'b00) begin n_bad++; $display("FAIL flush_wb_after: got %b want 00", bus.iss_valid); end
    endtask

    task automatic test_decode_illegal;
        do_reset;
        tick;
        bus.in_valid = 1'b1; bus.in_slot1_valid = 1'b1; bus.iss_ready = 1'b0;
        bus.in_instr0 = 32'hFFFFFFFF; bus.in_instr1 = 32'h00208463;
        tick;
        bus.in_valid = 1'b0;
        #4;
        n_cmp++; if (bus.iss_illegal !== 2'b01) begin n_bad++; $display("FAIL dec_illegal_pair: got %b want 01", bus.iss_illegal); end
        n_cmp++; if (bus.iss_rs1 !== {5'd1, 5'd0}) begin n_bad++; $display("FAIL dec_rs1: got %h want %h", bus.iss_rs1, {5'd1, 5'd0}); end
        n_cmp++; if (bus.iss_rs2 !== {5'd2, 5'd0}) begin n_bad++; $display("FAIL dec_rs2: got %h want %h", bus.iss_rs2, {5'd2, 5'd0}); end
        n_cmp++; if (bus.iss_rd !== 10'd0) begin n_bad++; $display("FAIL dec_rd: got %h want 0", bus.iss_rd); end
        n_cmp++; if (bus.iss_valid !== 2'b11) begin n_bad++; $display("FAIL dec_valid: got %b want 11", bus.iss_valid); end
        bus.iss_ready = 1'b1;
        tick;
        bus.in_valid = 1'b1; bus.in_slot1_valid = 1'b0;
        tick;
        bus.in_valid = 1'b0;
        #4;
        n_cmp++; if (bus.iss_illegal !== 2'b01) begin n_bad++; $display("FAIL single_illegal: got %b want 01", bus.iss_illegal); end
        n_cmp++; if (bus.iss_valid !== 2'b01) begin n_bad++; $display("FAIL single_valid: got %b want 01", bus.iss_valid); end
        n_cmp++; if (bus.iss_rd !== 10'd0) begin n_bad++; $display("FAIL single_rd: got %h want 0", bus.iss_rd); end
        tick;
        #4;
        n_cmp++; if (bus.sb_busy !== 32'h0) begin n_bad++; $display("FAIL illegal_no_set: got %h want 0", bus.sb_busy); end
    endtask

    task automatic test_set_wins;
        do_reset;
        tick;
        bus.in_valid = 1'b1; bus.in_slot1_valid = 1'b0; bus.iss_ready = 1'b1;
        bus.in_instr0 = 32'h00500293;
        tick;
        bus.in_valid = 1'b0;
        bus.wb_valid = 2'b01; bus.wb_rd = {5'd0, 5'd5};
        #4;
        n_cmp++; if (bus.iss_valid !== 2'b01) begin n_bad++; $display("FAIL setwin_valid: got %b want 01", bus.iss_valid); end
        tick;
        bus.wb_valid = 2'b00;
        #4;
        n_cmp++; if (bus.sb_busy !== 32'h20) begin n_bad++; $display("FAIL setwin_busy: got %h want 20", bus.sb_busy); end
        tick;
        bus.wb_valid = 2'b10; bus.wb_rd = {5'd5, 5'd0};
        tick;
        bus.wb_valid = 2'b00;
        #4;
        n_cmp++; if (bus.sb_busy !== 32'h0) begin n_bad++; $display("FAIL wb_port1_clear: got %h want 0", bus.sb_busy); end
    endtask

    task automatic test_rst_mid;
        do_reset;
        tick;
        bus.in_valid = 1'b1; bus.in_slot1_valid = 1'b1; bus.iss_ready = 1'b1;
        bus.in_instr0 = 32'h00500313; bus.in_instr1 = 32'h00700393;
        tick;
        bus.in_instr0 = 32'h00500413; bus.in_instr1 = 32'h00700493;
        tick;
        bus.in_valid = 1'b0; bus.iss_ready = 1'b0;
        #4;
        n_cmp++; if (bus.sb_busy !== 32'hC0) begin n_bad++; $display("FAIL rstmid_pre_busy: got %h want c0", bus.sb_busy); end
        tick;
        rst = 1'b1; bus.in_valid = 1'b1; bus.iss_ready = 1'b1;
        tick;
        rst = 1'b0; bus.in_valid = 1'b0;
        #4;
        n_cmp++; if (bus.iss_valid !== 2'b00) begin n_bad++; $display("FAIL rstmid_valid: got %b want 00", bus.iss_valid); end
        n_cmp++; if (bus.sb_busy !== 32'h0) begin n_bad++; $display("FAIL rstmid_busy: got %h want 0", bus.sb_busy); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.iss_rd !== 10'd0) begin n_bad++; $display("FAIL rstmid_rd: got %h want 0", bus.iss_rd); end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_slot1_valid = 1'b0;
        bus.in_instr0 = '0; bus.in_instr1 = '0;
        bus.flush = 1'b0; bus.iss_ready = 1'b0;
        bus.wb_valid = '0; bus.wb_rd = '0;
        test_reset;
        test_independent;
        test_intra_raw;
        test_backpressure;
        test_back_to_back;
        test_flush;
        test_decode_illegal;
        test_set_wins;
        test_rst_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
